// File: rtl/hci_package.sv
// hci_package: shared types for the HCI sink strobe generator.
package hci_package;

    typedef enum logic [1:0] {
        IDLE,
        WORK,
        DRAIN
    } hci_strbgen_state_t;

    typedef struct packed {
        logic ready_start;
        logic busy;
        logic done;
    } hci_strbgen_flags_t;

endpackage

// File: rtl/hci_core_sink_strbgen_outreg.sv
// hci_core_sink_strbgen_outreg: one-entry valid/ready register slice holding data and strobes.
module hci_strbgen_outreg
    import hci_package::*;
#(
    parameter int DW = 64,
    parameter int SW = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [SW-1:0] strb_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [SW-1:0] strb_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            strb_o  <= '0;
        end else if (enable_i) begin
            if (load_i) begin
                valid_o <= 1'b1;
                data_o  <= data_i;
                strb_o  <= strb_i;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hci_core_sink_strbgen.sv
// hci_core_sink_strbgen: turns a raw stream plus byte length into a strobed, length-bounded stream.
module hci_core_sink_strbgen
    import hci_package::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    start_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    ready_start_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int PW = DATA_WIDTH - 32;
    localparam int PB = PW / 8;
    localparam int LB = $clog2(PB);
    localparam int TW = (LB > 0) ? LB : 1;
    localparam int RW = LEN_WIDTH - LB + 1;
    localparam int SW = DATA_WIDTH / 8;

    hci_strbgen_state_t state_q, state_d;
    hci_strbgen_flags_t flags;
    logic [RW-1:0] rem_q, rem_d, n_beats;
    logic [TW-1:0] tail_q, tail_d;
    logic          done_q, done_d;
    logic          accept, drain, last_beat;
    logic [PB-1:0] strb_pay;
    logic          unused_hi;

    // Upper alignment headroom of the input is never forwarded.
    assign unused_hi = ^in_data_i[DATA_WIDTH-1:PW];

    assign n_beats   = RW'(({1'b0, len_i} + (LEN_WIDTH+1)'(PB - 1)) >> LB);
    assign last_beat = (rem_q == RW'(1));
    assign strb_pay  = (last_beat && tail_q != '0) ? ~({PB{1'b1}} << tail_q) : {PB{1'b1}};

    assign in_ready_o = enable_i && state_q == WORK && rem_q != '0 && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign drain      = enable_i && out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tail_d  = tail_q;
        done_d  = 1'b0;
        if (enable_i) begin
            if (state_q == IDLE && start_i) begin
                if (len_i == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = WORK;
                    rem_d   = n_beats;
                    tail_d  = TW'(len_i & LEN_WIDTH'(PB - 1));
                end
            end
            if (accept) begin
                rem_d   = rem_q - RW'(1);
                state_d = last_beat ? DRAIN : state_q;
            end
            if (state_q == DRAIN && (drain || !out_valid_o)) begin
                state_d = IDLE;
                done_d  = drain;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tail_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tail_q  <= tail_d;
            done_q  <= done_d;
        end
    end

    hci_strbgen_outreg #(
        .DW(DATA_WIDTH),
        .SW(SW)
    ) i_outreg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .enable_i(enable_i),
        .load_i  (accept),
        .data_i  ({{(DATA_WIDTH-PW){1'b0}}, in_data_i[PW-1:0]}),
        .strb_i  ({{(SW-PB){1'b0}}, strb_pay}),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .strb_o  (out_strb_o)
    );

    assign flags = '{ready_start: state_q == IDLE, busy: state_q != IDLE, done: done_q};
    assign ready_start_o = flags.ready_start;
    assign busy_o        = flags.busy;
    assign done_o        = flags.done;

endmodule

// File: doc/hci_core_sink_strbgen.md
# hci_core_sink_strbgen

Stream-conditioning stage placed directly upstream of the HCI core sink's stream port. It takes a raw data stream plus a byte length, and emits a stream with correct per-byte strobes (full on every beat, partial on the final one). It zeroes the upper 32-bit alignment headroom the sink reserves. It stops accepting input once the programmed length is reached and reports completion.

## Interface
- DATA_WIDTH, 64: stream width in bits; payload width PW = DATA_WIDTH-32, payload bytes PB = PW/8 (power of two, ≥1).
- LEN_WIDTH, 32: width of the byte-length field.
- clk_i  in  1  clock.
- rst_i  in  1  reset; **synchronous, active-high**; one clock, `clk_i`.
- clear_i  in  1  synchronous soft clear, same effect as reset.
- enable_i  in  1  global enable; low freezes all state, in_ready_o=0.
- start_i  in  1  start request, sampled only in IDLE.
- len_i  in  LEN_WIDTH  transfer length in bytes, sampled with start_i.
- in_valid_i / in_ready_o  in/out  1  input handshake.
- in_data_i  in  DATA_WIDTH  input data; only bits [PW-1:0] used.
- out_valid_o / out_ready_i  out/in  1  output handshake.
- out_data_o  out  DATA_WIDTH  data; bits [DATA_WIDTH-1:PW] always 0.
- out_strb_o  out  DATA_WIDTH/8  strobes; bits [DATA_WIDTH/8-1:PB] always 0.
- ready_start_o  out  1  high in IDLE.
- busy_o  out  1  high in WORK or DRAIN.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Beat count N = ceil(len/PB), computed at start; remaining counter rem_q loaded with N. Tail r = len mod PB.
- FSM states: IDLE, WORK, DRAIN.
  - IDLE → WORK on start_i with len≠0.
  - IDLE stays IDLE on start_i with len=0, and done_o pulses in the next cycle.
  - WORK → DRAIN when the input beat with rem_q=1 is accepted.
  - DRAIN → IDLE when the output register is empty. done_o pulses in the cycle after the final output handshake.
- in_ready_o = enable_i & (state==WORK) & (out register empty | out_ready_i). Outside WORK, input beats are never consumed.
- Each accepted beat is loaded into a single output register holding data, strb and valid. rem_q decrements by 1.
- Strobes: all PB bits set, except when rem_q=1 and r≠0, where strb = (1<<r)-1.
- Output register keeps data/strb stable while out_valid_o=1 and out_ready_i=0.
- enable_i=0: no state, counter or register changes; out_valid_o holds its value.

## Timing
- Reset/clear values: state=IDLE, rem_q=0, out_valid_o=0, out_data_o=0, out_strb_o=0, done_o=0, busy_o=0, ready_start_o=1.
- Latency: input accept to out_valid_o is 1 cycle.
- Throughput: 1 beat/cycle under continuous out_ready_i (simultaneous load and drain allowed).
- rem_q never underflows; a beat is accepted only while rem_q≥1.
- start_i while busy is ignored. len_i changes after start have no effect.
- clear_i/rst_i mid-transfer: the pending output beat is discarded, no done_o pulse, next cycle IDLE.
- len_i up to 2^LEN_WIDTH-1; rem_q width = LEN_WIDTH-log2(PB)+1.

## Structure
- hci_package: hci_strbgen_state_t enum {IDLE, WORK, DRAIN}; hci_strbgen_flags_t {ready_start, busy, done}.
- One sub-module, hci_strbgen_outreg: one-entry valid/ready register slice with load/drain logic. FSM, counter and strobe generation stay in the top module.

## Test plan
DATA_WIDTH=64, so PB=4.
- **len=10, continuous valid/ready:**
  - Beats 1 and 2 carry strb 0x0F; beat 3 carries strb 0x03.
  - out_strb_o[7:4]=0 and out_data_o[63:32]=0 throughout.
  - done_o pulses one cycle after the 3rd output handshake.
  - A 4th input beat stays unaccepted.
- **len=8:** exactly 2 beats, both strb 0x0F, then done_o.
- **len=0:** no out_valid_o; done_o pulses one cycle after start_i; ready_start_o stays 1.
- **len=12, out_ready_i low for 3 cycles on beat 2:**
  - out_data_o and out_strb_o are stable while stalled.
  - in_ready_o=0 while stalled.
  - Total beats = 3, all strb 0x0F.
- **len=20, clear_i after 2 output beats:** the next cycle shows IDLE, out_valid_o=0, no done_o; a new start with len=4 yields one beat with strb 0x0F.
- **enable_i low for 2 cycles mid-transfer:** no handshakes, rem_q frozen; completion ends with the correct final strb.
